// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
//   state_t        : responder FSM states (IDLE / WAIT / RESP)
//   MASK_LANES     : number of byte lanes in a 32-bit word
//   BASE_ADDR_DEFAULT : first byte address served by default
//   req_t          : captured request fields carried from accept to commit
//   addr_in_range(): unsigned window check, wraps below base to an error
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int MASK_LANES = 4;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic                  wen;
    logic [31:0]           wdata;
    logic [MASK_LANES-1:0] wmask;
    logic                  err;
  } req_t;

  // The offset is computed modulo 2^32, so addresses below base become huge
  // offsets and fail the compare. The limit is widened so 4*depth cannot wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_words);
    logic [33:0] offset;
    logic [33:0] limit;
    offset = {2'b00, addr - base};
    limit  = 34'(depth_words) << 2;
    return offset < limit;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between a core load/store port and the memory
// responder. Both directions use valid/ready; a transfer happens on the
// rising edge where valid and ready are both high.
//   req_*  : master -> slave request (req_ready flows back)
//   resp_* : slave -> master response (resp_ready flows back)
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_word_array.sv
// Single-port DEPTH_WORDS x 32 word storage with per-lane write enables and
// a registered read port.
//   clk, rst_n : clock and asynchronous active-low reset (read register only)
//   en         : access this cycle
//   wr         : 1 = write lanes selected by we, 0 = read into rdata
//   we         : byte-lane write enables, lane i = bits [8i+7:8i]
//   idx        : word index
//   wdata      : write data
//   rdata      : read data, updated only on a read access
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr,
  input  logic [MASK_LANES-1:0] we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset; clearing it would force flops
  // instead of RAM, so only the read register below is reset.
  always_ff @(posedge clk) begin
    if (en && wr) begin
      for (int i = 0; i < MASK_LANES; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata <= '0;
    else if (en && !wr)  rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one load/store at a time, waits
// a programmable number of cycles, commits the access and returns a response.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mem_responder_if slave modport (request and response channels)
// Parameters: BASE_ADDR (first byte served), DEPTH_WORDS (power of two),
// LATENCY (0..15; response valid LATENCY+1 cycles after accept).
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           state;
  logic [3:0]       cnt;
  req_t             lat_req;
  logic [IDX_W-1:0] lat_idx;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             resp_rd_q;
  logic [31:0]      arr_rdata;

  logic [31:0]      offset;
  req_t             live_req;
  logic [IDX_W-1:0] live_idx;
  req_t             c_req;
  logic [IDX_W-1:0] c_idx;
  logic             accept;
  logic             commit;
  logic             unused_bits;

  assign offset         = bus.req_addr - BASE_ADDR;
  assign live_idx       = offset[IDX_W+1:2];
  assign live_req.wen   = bus.req_wen;
  assign live_req.wdata = bus.req_wdata;
  assign live_req.wmask = bus.req_wmask[MASK_LANES-1:0];
  assign live_req.err   = !addr_in_range(bus.req_addr, BASE_ADDR, DEPTH_WORDS);
  assign unused_bits    = ^{offset[31:IDX_W+2], offset[1:0], bus.req_wmask[7:MASK_LANES]};

  assign accept = (state == IDLE) && bus.req_valid;

  // With zero latency the accept edge is also the commit edge, so the live
  // request drives the array; otherwise the latched copy does. Reset gates
  // the commit so a request presented during reset never touches the array.
  assign commit = rst_n && ((accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1)));
  assign c_req  = (state == IDLE) ? live_req : lat_req;
  assign c_idx  = (state == IDLE) ? live_idx : lat_idx;

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit && !c_req.err),
    .wr    (c_req.wen),
    .we    (c_req.wmask),
    .idx   (c_idx),
    .wdata (c_req.wdata),
    .rdata (arr_rdata)
  );

  // NOTE: every state register here uses <= so all of them update from the
  // same pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_req      <= '0;
      lat_idx      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_req <= live_req;
            lat_idx <= live_idx;
            cnt     <= 4'(LATENCY);
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Commit never coincides with the RESP handshake, so no priority clash.
      if (commit) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= c_req.err;
        resp_rd_q    <= !c_req.wen && !c_req.err;
      end
    end
  end

  // The array read register only changes on a read commit, so it holds steady
  // throughout RESP; writes and errors report zero data.
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rd_q ? arr_rdata : 32'h0;

endmodule
